// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the data bus,
// one-shot or auto-reload counting with a maskable level interrupt.
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic [1:0]  reg_sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        unused_addr;

    assign reg_sel     = Addr[3:2];
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign wr_ctrl     = WE && (reg_sel == A_CTRL);
    assign wr_preset   = WE && (reg_sel == A_PRESET);
    assign auto_reload = (mode_q == MODE_RELOAD);

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        unique case (state_q)
            S_IDLE: begin
                if (en_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = S_INT;
                    irq_d   = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    irq_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // CPU writes come last so they override same-cycle FSM updates
        if (wr_ctrl) begin
            en_d   = DIN[0];
            mode_d = DIN[2:1];
            im_d   = DIN[3];
            irq_d  = 1'b0;
        end

        if (wr_preset) begin
            preset_d = DIN;
            irq_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        DOUT = 32'd0;
        unique case (reg_sel)
            A_CTRL:   DOUT = {28'd0, im_q, mode_q, en_q};
            A_PRESET: DOUT = preset_q;
            A_COUNT:  DOUT = count_q;
            default:  DOUT = 32'd0;
        endcase
    end

    assign IRQ = irq_q & im_q;

endmodule
